// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC read sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DRDY,
    CMD,
    T6,
    READ,
    FINISH
  } state_t;

  localparam logic [7:0] CMD_RDATA_DEFAULT = 8'h01;
  localparam logic [7:0] DUMMY_BYTE        = 8'h00;

endpackage

// File: rtl/drdy_sync.sv
// Brings the asynchronous active-low DRDY into the clock domain and
// emits a one-cycle pulse on each falling edge.
module drdy_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic drdy_n_i,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Two-flop synchroniser plus one delayed copy; all reset high so a low
  // DRDY at reset release is not mistaken for an edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= drdy_n_i;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign fall_o = r_sync_d & ~r_sync;

endmodule

// File: rtl/adc_read_seq.sv
// Frames one ADC read: RDATA command, t6 wait, BYTES dummy reads assembled
// MSB-first, then hands the sample to a valid/ready stream.
module adc_read_seq
  import adc_seq_pkg::*;
#(
  parameter int         BYTES     = 3,
  parameter int         T6_CYCLES = 50,
  parameter logic [7:0] CMD_RDATA = CMD_RDATA_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 drdy_n_i,
  output logic                 spi_start_o,
  output logic [7:0]           spi_tx_o,
  input  logic                 spi_done_i,
  input  logic [7:0]           spi_rx_i,
  output logic                 cs_n_o,
  output logic [8*BYTES-1:0]   sample_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 overrun_o,
  input  logic                 clear_overrun_i
);

  localparam int              SW        = 8 * BYTES;
  localparam int              DW        = (T6_CYCLES > 1) ? $clog2(T6_CYCLES) : 1;
  localparam logic [DW-1:0]   DLY_LAST  = DW'(T6_CYCLES - 1);
  localparam logic [2:0]      BYTE_LAST = 3'(BYTES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_fall;
  logic            r_pending;
  logic [DW-1:0]   r_dly;
  logic [2:0]      r_byte_cnt;
  logic [SW-1:0]   r_shreg;
  logic            r_cs_n;
  logic [SW-1:0]   r_sample;
  logic            r_valid;
  logic            r_overrun;

  logic            w_start;
  logic [7:0]      w_tx;
  logic            w_consume;
  logic            w_shift;
  logic            w_finish;
  logic            w_load;

  drdy_sync u_drdy_sync (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .drdy_n_i (drdy_n_i),
    .fall_o   (w_fall)
  );

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and the combinational SPI start/byte strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_tx        = 8'h00;
    w_consume   = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_nxt = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        if (!enable_i) begin
          w_state_nxt = IDLE;
        end else if (r_pending) begin
          w_consume   = 1'b1;
          w_start     = 1'b1;
          w_tx        = CMD_RDATA;
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        if (spi_done_i) w_state_nxt = T6;
      end
      T6: begin
        if (r_dly == DLY_LAST) begin
          w_start     = 1'b1;
          w_tx        = DUMMY_BYTE;
          w_state_nxt = READ;
        end
      end
      READ: begin
        if (spi_done_i) begin
          w_shift = 1'b1;
          // Chain the next byte in the done cycle so the frame has no gaps.
          if (r_byte_cnt != BYTE_LAST) begin
            w_start = 1'b1;
            w_tx    = DUMMY_BYTE;
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        w_finish    = 1'b1;
        w_state_nxt = enable_i ? WAIT_DRDY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // The SPI master shares our reset; never hand it a start while resetting.
    if (reset_i) begin
      w_start = 1'b0;
      w_tx    = 8'h00;
    end
  end

  assign w_load = w_finish && (!r_valid || sample_ready_i);

  // Control registers: DRDY pending, counters, chip select, output stream, overrun.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pending  <= 1'b0;
      r_dly      <= '0;
      r_byte_cnt <= '0;
      r_cs_n     <= 1'b1;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // A fresh edge wins over consumption so it is never lost.
      if (w_fall)         r_pending <= 1'b1;
      else if (w_consume) r_pending <= 1'b0;

      if (r_state == T6) r_dly <= r_dly + DW'(1);
      else               r_dly <= '0;

      if (w_consume)    r_byte_cnt <= '0;
      else if (w_shift) r_byte_cnt <= r_byte_cnt + 3'd1;

      if (w_consume)     r_cs_n <= 1'b0;
      else if (w_finish) r_cs_n <= 1'b1;

      if (w_load) begin
        r_sample <= r_shreg;
        r_valid  <= 1'b1;
      end else if (r_valid && sample_ready_i) begin
        r_valid  <= 1'b0;
      end

      if (w_finish && !w_load) r_overrun <= 1'b1;
      else if (clear_overrun_i) r_overrun <= 1'b0;
    end
  end

  // Sample shift register; each frame overwrites all bytes, so no reset needed.
  always_ff @(posedge clock_i) begin
    if (w_shift) r_shreg <= SW'({r_shreg, spi_rx_i});
  end

  assign spi_start_o    = w_start;
  assign spi_tx_o       = w_tx;
  assign cs_n_o         = r_cs_n;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_adc_read_seq.sv
// Self-checking bench for adc_read_seq with an SPI slave model and a
// frame-level reference model of the sample stream.
module tb_adc_read_seq;

  localparam int         BYTES = 3;
  localparam int         T6    = 50;
  localparam int         SW    = 8 * BYTES;
  localparam logic [7:0] CMD   = 8'h01;

  logic          clock_i;
  logic          reset_i;
  logic          enable_i;
  logic          drdy_n_i;
  logic          spi_start_o;
  logic [7:0]    spi_tx_o;
  logic          spi_done_i;
  logic [7:0]    spi_rx_i;
  logic          cs_n_o;
  logic [SW-1:0] sample_o;
  logic          sample_valid_o;
  logic          sample_ready_i;
  logic          overrun_o;
  logic          clear_overrun_i;

  adc_read_seq #(.BYTES(BYTES), .T6_CYCLES(T6), .CMD_RDATA(CMD)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .drdy_n_i        (drdy_n_i),
    .spi_start_o     (spi_start_o),
    .spi_tx_o        (spi_tx_o),
    .spi_done_i      (spi_done_i),
    .spi_rx_i        (spi_rx_i),
    .cs_n_o          (cs_n_o),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o),
    .sample_ready_i  (sample_ready_i),
    .overrun_o       (overrun_o),
    .clear_overrun_i (clear_overrun_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor-owned state
  int            cyc = 0;
  int            phase = 0;        // 0 idle, 1 cmd, 2 t6, 3 read, 4 finish
  int            frames = 0;
  int            last_start_cyc = 0;
  // Main-owned state
  int            last_edge_cyc = -1;
  logic [7:0]    dir_bytes [4];
  int            dir_req = 0;
  int            rmode = 0;        // 0 never, 1 random, 2 always, 3 only in FINISH

  // SPI slave model plus reference model of frame timing and output stream.
  initial begin
    int            spi_cnt;
    bit            spi_busy;
    int            cmd_done_cyc;
    int            nrx;
    int            nstart;
    int            bidx;
    bit            use_dir;
    int            dir_seen;
    logic [SW-1:0] shx;
    logic [SW-1:0] ms;
    bit            mv, mo, exp_cs, fin, drop, exp_st;
    spi_cnt = 0; spi_busy = 0; cmd_done_cyc = 0; nrx = 0; nstart = 0;
    bidx = 0; use_dir = 0; dir_seen = 0; shx = '0; ms = '0;
    mv = 0; mo = 0; exp_cs = 1;
    spi_done_i = 1'b0;
    spi_rx_i   = 8'h00;
    forever begin
      @(negedge clock_i);
      cyc++;
      spi_done_i = 1'b0;
      if (spi_busy) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          spi_busy   = 0;
          spi_done_i = 1'b1;
          spi_rx_i   = (use_dir && bidx < 4) ? dir_bytes[bidx] : 8'($urandom);
          bidx++;
        end
      end
      #1;
      if (reset_i) begin
        mv = 0; mo = 0; ms = '0; exp_cs = 1; phase = 0; spi_busy = 0;
        last_start_cyc = cyc;
      end else begin
        chk("cs_n", cs_n_o, exp_cs);
        chk("valid", sample_valid_o, mv);
        if (mv) chk("sample", sample_o, ms);
        chk("overrun", overrun_o, mo);
        fin = (phase == 4);
        case (phase)
          0: begin
            if (spi_start_o) begin
              chk("cmd_tx", spi_tx_o, CMD);
              chk("cmd_req", last_edge_cyc > last_start_cyc, 1);
              chk("cmd_en", enable_i, 1);
              last_start_cyc = cyc;
              phase = 1; nstart = 1; bidx = 0; nrx = 0; shx = '0;
              use_dir = (dir_req != dir_seen);
              dir_seen = dir_req;
              exp_cs = 0;
            end
          end
          1: begin
            chk("start_in_cmd", spi_start_o, 0);
            if (spi_done_i) begin
              cmd_done_cyc = cyc;
              phase = 2;
            end
          end
          2: begin
            exp_st = (cyc == cmd_done_cyc + T6);
            chk("t6_start", spi_start_o, exp_st);
            if (spi_start_o && exp_st) begin
              chk("data_tx", spi_tx_o, 8'h00);
              nstart++;
              phase = 3;
            end
          end
          3: begin
            if (spi_done_i) begin
              shx = {shx[SW-9:0], spi_rx_i};
              nrx++;
            end
            exp_st = spi_done_i && (nrx < BYTES);
            chk("chain_start", spi_start_o, exp_st);
            if (spi_start_o && exp_st) begin
              chk("data_tx", spi_tx_o, 8'h00);
              nstart++;
            end
            if (nrx == BYTES) phase = 4;
          end
          default: begin
            chk("start_in_finish", spi_start_o, 0);
            chk("starts_per_frame", nstart, 1 + BYTES);
            frames++;
            phase = 0;
            exp_cs = 1;
          end
        endcase
        if (spi_start_o) begin
          chk("spi_overlap", spi_busy, 0);
          spi_busy = 1;
          spi_cnt  = $urandom_range(2, 6);
        end
        drop = fin && mv && !sample_ready_i;
        if (fin) begin
          if (!drop) begin
            ms = shx;
            mv = 1;
          end
        end else if (mv && sample_ready_i) begin
          mv = 0;
        end
        if (drop) mo = 1;
        else if (clear_overrun_i) mo = 0;
      end
    end
  end

  // Consumer ready policy.
  initial begin
    sample_ready_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      case (rmode)
        0:       sample_ready_i = 1'b0;
        1:       sample_ready_i = 1'($urandom_range(0, 1));
        2:       sample_ready_i = 1'b1;
        default: sample_ready_i = (phase == 4);
      endcase
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic pulse_drdy();
    drdy_n_i = 1'b0;
    last_edge_cyc = cyc;
    repeat (3) step();
    drdy_n_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic set_dir(input logic [7:0] b0, b1, b2, b3);
    dir_bytes[0] = b0; dir_bytes[1] = b1; dir_bytes[2] = b2; dir_bytes[3] = b3;
    dir_req++;
  endtask

  task automatic wait_phase(input int p, input int lim);
    for (int i = 0; i < lim && phase != p; i++) step();
    chk("reach_phase", phase, p);
  endtask

  task automatic wait_frames(input int target, input int lim);
    for (int i = 0; i < lim && frames < target; i++) step();
  endtask

  task automatic episode(input int k, input bit drop_en);
    int f0;
    int nexp;
    f0 = frames;
    nexp = (k > 0) ? 2 : 1;
    pulse_drdy();
    if (k > 0 || drop_en) begin
      wait_phase(2, 500);
      for (int j = 0; j < k; j++) pulse_drdy();
      if (drop_en) enable_i = 1'b0;
    end
    wait_frames(f0 + nexp, 3000);
    repeat (200) step();
    chk("frames", frames - f0, nexp);
  endtask

  // Directed scenarios followed by randomized episodes.
  initial begin
    int f0;
    reset_i = 1'b1; enable_i = 1'b0; drdy_n_i = 1'b1; clear_overrun_i = 1'b0;
    for (int i = 0; i < 4; i++) dir_bytes[i] = 8'h00;
    repeat (4) step();
    reset_i = 1'b0;
    step();
    chk("rst_cs_n", cs_n_o, 1);
    chk("rst_start", spi_start_o, 0);
    chk("rst_tx", spi_tx_o, 8'h00);
    chk("rst_sample", sample_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_overrun", overrun_o, 0);
    enable_i = 1'b1;
    repeat (5) step();

    // Basic frame, assembled MSB-first, consumer stalled.
    rmode = 0;
    set_dir(8'hA5, 8'h12, 8'h34, 8'h56);
    episode(0, 0);
    chk("basic_sample", sample_o, 24'h123456);
    chk("basic_valid", sample_valid_o, 1);

    // Drain, then two frames with no consumer: second is dropped.
    rmode = 2; repeat (3) step(); rmode = 0;
    set_dir(8'h00, 8'h00, 8'h00, 8'h01);
    episode(0, 0);
    set_dir(8'h00, 8'h00, 8'h00, 8'h02);
    episode(0, 0);
    chk("ovr_sample", sample_o, 24'h000001);
    chk("ovr_flag", overrun_o, 1);
    clear_overrun_i = 1'b1; step(); clear_overrun_i = 1'b0; step();
    chk("ovr_clear", overrun_o, 0);

    // Accept in the FINISH cycle while valid: replace without overrun.
    rmode = 3;
    set_dir(8'h00, 8'h00, 8'h00, 8'h03);
    episode(0, 0);
    chk("swap_sample", sample_o, 24'h000003);
    chk("swap_valid", sample_valid_o, 1);
    chk("swap_overrun", overrun_o, 0);

    // Edges mid-frame collapse into a single extra frame.
    rmode = 1;
    episode(1, 0);
    episode(2, 0);

    // Disable during T6: frame completes, then no new frames until enabled.
    rmode = 2;
    set_dir(8'h00, 8'hCA, 8'hFE, 8'h42);
    episode(0, 1);
    chk("dis_sample", sample_o, 24'hCAFE42);
    f0 = frames;
    pulse_drdy();
    repeat (300) step();
    chk("dis_no_frame", frames - f0, 0);
    enable_i = 1'b1;
    wait_frames(f0 + 1, 3000);
    repeat (100) step();
    chk("dis_resume", frames - f0, 1);

    // Reset in the middle of READ.
    rmode = 0;
    pulse_drdy();
    wait_phase(3, 500);
    step();
    reset_i = 1'b1; step(); reset_i = 1'b0;
    chk("rstmid_cs_n", cs_n_o, 1);
    chk("rstmid_start", spi_start_o, 0);
    chk("rstmid_valid", sample_valid_o, 0);
    f0 = frames;
    repeat (150) step();
    chk("rstmid_no_frame", frames - f0, 0);

    // Randomized episodes.
    for (int e = 0; e < 10; e++) begin
      int  k;
      bit  drop_en;
      rmode = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        set_dir(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      k = $urandom_range(0, 2);
      drop_en = (k == 0) && ($urandom_range(0, 3) == 0);
      episode(k, drop_en);
      enable_i = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        clear_overrun_i = 1'b1; step(); clear_overrun_i = 1'b0;
      end
      repeat (5) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_read_seq.md
Name: adc_read_seq

Overview:
Upstream sequencer for the 8-bit SPI master. It waits for the ADC data-ready strobe, then issues an RDATA command byte over SPI. After the t6 command-to-data delay it clocks in BYTES dummy bytes and assembles them MSB-first into one sample word. It holds a frame-wide chip select across all bytes, because the SPI master's own CS drops between bytes, and presents each sample on a valid/ready stream to the DAQ buffer.

Parameters:
BYTES, 3, data bytes per sample (1..4); sample width = 8*BYTES
T6_CYCLES, 50, clock_i cycles between command-byte done and first data-byte start (>=1)
CMD_RDATA, 8'h01, command byte sent at frame start

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  level; 1 = service DRDY events, 0 = finish current frame then idle
drdy_n_i  in  1  asynchronous ADC data-ready, active low
spi_start_o  out  1  one-cycle start pulse to SPI master
spi_tx_o  out  8  byte to transmit; valid whenever spi_start_o=1
spi_done_i  in  1  one-cycle pulse from SPI master; spi_rx_i valid this cycle
spi_rx_i  in  8  received byte
cs_n_o  out  1  frame chip select, active low
sample_o  out  8*BYTES  assembled sample, first byte received in MSBs
sample_valid_o  out  1  sample_o valid; held until accepted
sample_ready_i  in  1  consumer accepts when valid&ready
overrun_o  out  1  sticky: a completed sample was dropped
clear_overrun_i  in  1  one-cycle clear of overrun_o

Behaviour:
- Reset values: spi_start_o=0, spi_tx_o=0, cs_n_o=1, sample_o=0, sample_valid_o=0, overrun_o=0; drdy_pending=0; FSM=IDLE; counters=0.
- DRDY: 2-flop synchroniser, then falling-edge detect. Each detected edge sets drdy_pending. The pending flag clears when WAIT_DRDY consumes it. An edge arriving mid-frame stays pending; multiple edges collapse into one.
- FSM states:
  - IDLE: if enable_i, go to WAIT_DRDY.
  - WAIT_DRDY: if !enable_i, go to IDLE. Else if drdy_pending: cs_n_o<=0, spi_start_o=1, spi_tx_o=CMD_RDATA, byte_cnt<=0, go to CMD.
  - CMD: wait for spi_done_i (rx ignored), then T6 with delay counter cleared.
  - T6: count T6_CYCLES. On the cycle the count reaches T6_CYCLES-1: spi_start_o=1, spi_tx_o=8'h00, go to READ.
  - READ: on spi_done_i, shift spi_rx_i into the shift register's LSB (shreg<={shreg[8*BYTES-9:0],rx}) and byte_cnt++.
    - If byte_cnt != BYTES-1: chain with spi_start_o=1 in the same cycle, spi_tx_o=8'h00.
    - Else: go to FINISH.
  - FINISH (1 cycle): cs_n_o<=1, deliver sample, then WAIT_DRDY if enable_i else IDLE.
- cs_n_o is registered. It goes low in the same cycle the command spi_start_o is driven, and stays low until FINISH.
- Total cs_n_o low time covers the 1 command byte, T6_CYCLES of delay, and BYTES data bytes.
- Delivery in FINISH:
  - If !sample_valid_o, or sample_ready_i in that cycle: sample_o<=shreg, sample_valid_o<=1.
  - Else: the new sample is dropped, the old sample is kept, and overrun_o<=1.
- Output handshake: sample_valid_o clears on valid&ready unless FINISH loads a new sample in the same cycle. A sample is never lost or duplicated on simultaneous accept and load.
- overrun_o: set has priority over clear_overrun_i in the same cycle.
- enable_i deassert mid-frame: no abort, because the SPI master cannot abort. The frame completes and its sample is delivered normally.
- spi_start_o is never asserted outside the listed cases. Exactly 1+BYTES start pulses occur per frame.
- reset_i mid-frame: everything returns to reset values immediately. The SPI master shares the reset.

Decomposition:
- Package adc_seq_pkg: state_t enum (IDLE, WAIT_DRDY, CMD, T6, READ, FINISH), CMD_RDATA_DEFAULT=8'h01, DUMMY_BYTE=8'h00.
- One sub-module drdy_sync: 2-flop synchroniser plus falling-edge pulse, with clock_i/reset_i. Reset state is synced=1, so no spurious edge after reset.
- Delay and byte counters stay inline.

Test Plan:
- enable_i=1, pulse drdy_n_i low, SPI model returns 8'hA5,8'h12,8'h34,8'h56 -> exactly 4 spi_start_o pulses; spi_tx_o 8'h01 then 8'h00 x3; sample_o=24'h123456; sample_valid_o=1; cs_n_o low for the whole frame.
- Measure command done to next start with T6_CYCLES=50 -> exactly 50 cycles; data bytes chain, with spi_start_o in the same cycle as spi_done_i.
- Hold sample_ready_i=0 across two DRDY frames (samples 24'h000001, 24'h000002) -> sample_o stays 24'h000001; overrun_o=1. clear_overrun_i -> 0.
- sample_ready_i=1 in the FINISH cycle while valid -> old sample accepted, new sample loaded, valid stays 1, overrun_o=0.
- Second drdy_n_i falling edge mid-frame -> exactly one more frame follows. Two edges mid-frame -> still only one.
- Drop enable_i during the T6 state -> frame completes and the sample is delivered, then IDLE. Also assert reset_i during READ -> next cycle cs_n_o=1, spi_start_o=0, sample_valid_o=0.
